// File: rtl/counter_access_sequencer_if.sv
// Bus-side pin group of the timer sequencer: CPU chip-select, strobes, address,
// write data, read data and the read-data enable for the external tristate.
//   master : CPU side (drives strobes/address/write data)
//   slave  : sequencer side (drives read data and its valid flag)
interface counter_access_sequencer_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_out_valid;

  modport master (
    output cs_n, rd_n, wr_n, addr, data_in,
    input  data_out, data_out_valid
  );

  modport slave (
    input  cs_n, rd_n, wr_n, addr, data_in,
    output data_out, data_out_valid
  );
endinterface

// File: rtl/counter_access_sequencer.sv
// Bus-side sequencer for an 8253-style timer. Decodes the CPU bus, routes
// mode-setting control words, runs the per-counter LSB/MSB byte pointers for
// count loads and read-back, and holds the count/status latches.
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   bus (slave modport)     CPU pins: cs_n, rd_n, wr_n, addr, data_in / data_out, data_out_valid
//   cw_write_o, cw_o        1-cycle pulse + last mode-setting control word
//   count_load_o            one-hot 1-cycle pulse per counter, count_load_value_o holds the count
//   count_value{0,1,2}_i    live counts, status{0,1,2}_i status bytes
//
// state       | meaning
// W_LSB/R_LSB | next byte written/read is the low byte
// W_MSB/R_MSB | next byte written/read is the high byte (RW=11 only)
module counter_access_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  counter_access_sequencer_if.slave bus,
  output logic        cw_write_o,
  output logic [7:0]  cw_o,
  output logic [2:0]  count_load_o,
  output logic [15:0] count_load_value_o,
  input  logic [15:0] count_value0_i,
  input  logic [15:0] count_value1_i,
  input  logic [15:0] count_value2_i,
  input  logic [7:0]  status0_i,
  input  logic [7:0]  status1_i,
  input  logic [7:0]  status2_i
);

  typedef enum logic {W_LSB, W_MSB} wstate_t;
  typedef enum logic {R_LSB, R_MSB} rstate_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_STATUS, SRC_LATCH, SRC_LIVE} src_t;

  logic [SYNC_STAGES-1:0] rd_sync_q, wr_sync_q;
  logic rd_prev_q, wr_prev_q;
  logic rd_s, wr_s, rd_fall, rd_rise, wr_fall, wr_rise;

  logic [15:0] cv [3];
  logic [7:0]  st [3];

  logic [1:0]  rw_q        [3];
  wstate_t     wptr_q      [3];
  rstate_t     rptr_q      [3];
  logic [7:0]  lsb_q       [3];
  logic [15:0] cnt_latch_q [3];
  logic        cnt_full_q  [3];
  logic [7:0]  st_latch_q  [3];
  logic        st_full_q   [3];

  logic [1:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        wr_ok_q;
  logic        rd_active_q;
  src_t        rd_src_q;
  logic [1:0]  rd_ctr_q;
  logic [7:0]  data_out_q;
  logic        data_out_valid_q;

  logic [7:0]  rd_data_d;
  src_t        rd_src_d;
  logic [15:0] rd_word;
  logic        rd_msb;

  assign cv[0] = count_value0_i;
  assign cv[1] = count_value1_i;
  assign cv[2] = count_value2_i;
  assign st[0] = status0_i;
  assign st[1] = status1_i;
  assign st[2] = status2_i;

  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = data_out_valid_q;

  // Strobes are asynchronous to clk_i; both reset to the idle (high) level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      rd_prev_q <= 1'b1;
      wr_prev_q <= 1'b1;
    end else begin
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], bus.rd_n};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], bus.wr_n};
      rd_prev_q <= rd_s;
      wr_prev_q <= wr_s;
    end
  end

  assign rd_s    = rd_sync_q[SYNC_STAGES-1];
  assign wr_s    = wr_sync_q[SYNC_STAGES-1];
  assign rd_fall = rd_prev_q & ~rd_s;
  assign rd_rise = ~rd_prev_q & rd_s;
  assign wr_fall = wr_prev_q & ~wr_s;
  assign wr_rise = ~wr_prev_q & wr_s;

  // Read source: status latch first, then count latch, then the live count.
  always_comb begin
    rd_data_d = 8'h00;
    rd_src_d  = SRC_NONE;
    rd_word   = 16'h0000;
    rd_msb    = 1'b0;
    if (bus.addr != 2'd3) begin
      rd_msb = (rw_q[bus.addr] == 2'b10) ||
               (rw_q[bus.addr] == 2'b11 && rptr_q[bus.addr] == R_MSB);
      if (cnt_full_q[bus.addr]) rd_word = cnt_latch_q[bus.addr];
      else                      rd_word = cv[bus.addr];
      if (st_full_q[bus.addr]) begin
        rd_data_d = st_latch_q[bus.addr];
        rd_src_d  = SRC_STATUS;
      end else begin
        rd_data_d = rd_msb ? rd_word[15:8] : rd_word[7:0];
        rd_src_d  = cnt_full_q[bus.addr] ? SRC_LATCH : SRC_LIVE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < 3; n++) begin
        rw_q[n]        <= 2'b01;
        wptr_q[n]      <= W_LSB;
        rptr_q[n]      <= R_LSB;
        lsb_q[n]       <= 8'h00;
        cnt_latch_q[n] <= 16'h0000;
        cnt_full_q[n]  <= 1'b0;
        st_latch_q[n]  <= 8'h00;
        st_full_q[n]   <= 1'b0;
      end
      wr_addr_q          <= 2'd0;
      wr_data_q          <= 8'h00;
      wr_ok_q            <= 1'b0;
      rd_active_q        <= 1'b0;
      rd_src_q           <= SRC_NONE;
      rd_ctr_q           <= 2'd0;
      data_out_q         <= 8'h00;
      data_out_valid_q   <= 1'b0;
      cw_write_o         <= 1'b0;
      cw_o               <= 8'h00;
      count_load_o       <= 3'b000;
      count_load_value_o <= 16'h0000;
    end else begin
      cw_write_o   <= 1'b0;
      count_load_o <= 3'b000;

      // A write only counts if chip-select was low and no read overlapped it.
      if (wr_fall) begin
        wr_addr_q <= bus.addr;
        wr_data_q <= bus.data_in;
        wr_ok_q   <= ~bus.cs_n & rd_s;
      end

      if (wr_rise && wr_ok_q && rd_s) begin
        wr_ok_q <= 1'b0;
        if (wr_addr_q == 2'd3) begin
          if (wr_data_q[7:6] != 2'b11) begin
            if (wr_data_q[5:4] != 2'b00) begin
              rw_q[wr_data_q[7:6]]       <= wr_data_q[5:4];
              wptr_q[wr_data_q[7:6]]     <= W_LSB;
              rptr_q[wr_data_q[7:6]]     <= R_LSB;
              cnt_full_q[wr_data_q[7:6]] <= 1'b0;
              st_full_q[wr_data_q[7:6]]  <= 1'b0;
              cw_o       <= wr_data_q;
              cw_write_o <= 1'b1;
            end else if (!cnt_full_q[wr_data_q[7:6]]) begin
              cnt_latch_q[wr_data_q[7:6]] <= cv[wr_data_q[7:6]];
              cnt_full_q[wr_data_q[7:6]]  <= 1'b1;
            end
          end else begin
            // Read-back: D5/D4 are active-low count/status selects.
            for (int n = 0; n < 3; n++) begin
              if (wr_data_q[n+1]) begin
                if (!wr_data_q[5] && !cnt_full_q[n]) begin
                  cnt_latch_q[n] <= cv[n];
                  cnt_full_q[n]  <= 1'b1;
                end
                if (!wr_data_q[4] && !st_full_q[n]) begin
                  st_latch_q[n] <= st[n];
                  st_full_q[n]  <= 1'b1;
                end
              end
            end
          end
        end else begin
          case (rw_q[wr_addr_q])
            2'b01: begin
              count_load_value_o      <= {8'h00, wr_data_q};
              count_load_o[wr_addr_q] <= 1'b1;
            end
            2'b10: begin
              count_load_value_o      <= {wr_data_q, 8'h00};
              count_load_o[wr_addr_q] <= 1'b1;
            end
            2'b11: begin
              if (wptr_q[wr_addr_q] == W_LSB) begin
                lsb_q[wr_addr_q]  <= wr_data_q;
                wptr_q[wr_addr_q] <= W_MSB;
              end else begin
                count_load_value_o      <= {wr_data_q, lsb_q[wr_addr_q]};
                count_load_o[wr_addr_q] <= 1'b1;
                wptr_q[wr_addr_q]       <= W_LSB;
              end
            end
            default: ;
          endcase
        end
      end

      if (!rd_s && !wr_s) begin
        data_out_valid_q <= 1'b0;
        rd_active_q      <= 1'b0;
      end else if (rd_fall && !bus.cs_n && wr_s) begin
        data_out_q       <= rd_data_d;
        data_out_valid_q <= 1'b1;
        rd_active_q      <= 1'b1;
        rd_src_q         <= rd_src_d;
        rd_ctr_q         <= bus.addr;
      end else if (rd_rise && rd_active_q) begin
        data_out_valid_q <= 1'b0;
        rd_active_q      <= 1'b0;
        if (rd_src_q == SRC_STATUS) begin
          st_full_q[rd_ctr_q] <= 1'b0;
        end else if (rd_src_q != SRC_NONE) begin
          // The count latch frees up once its final byte has gone out.
          if (rd_src_q == SRC_LATCH &&
              (rw_q[rd_ctr_q] != 2'b11 || rptr_q[rd_ctr_q] == R_MSB))
            cnt_full_q[rd_ctr_q] <= 1'b0;
          if (rw_q[rd_ctr_q] == 2'b11)
            rptr_q[rd_ctr_q] <= (rptr_q[rd_ctr_q] == R_LSB) ? R_MSB : R_LSB;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_access_sequencer.sv
module tb_counter_access_sequencer;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_SET} op_t;
  typedef struct {
    op_t         op;
    logic [1:0]  addr;
    logic [7:0]  data;
    logic        cs_n;
    logic [15:0] val;      // SET: value to drive; WR: expected load value
    logic [2:0]  exp_load; // 000 = no load pulse expected
    logic        exp_cw;
    logic [7:0]  exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        cw_write;
  logic [7:0]  cw_out;
  logic [2:0]  count_load;
  logic [15:0] count_load_value;
  logic [15:0] cv0 = 16'h0, cv1 = 16'h0, cv2 = 16'h0;
  logic [7:0]  st0 = 8'h0, st1 = 8'h0, st2 = 8'h0;

  int n_checks = 0;
  int n_fail = 0;
  int load_cnt = 0;
  int cw_cnt = 0;
  logic [2:0]  last_mask = 3'b0;
  logic [15:0] last_val = 16'h0;
  vec_t vq[$];

  counter_access_sequencer_if bus_if ();

  counter_access_sequencer #(.SYNC_STAGES(2)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .bus                (bus_if),
    .cw_write_o         (cw_write),
    .cw_o               (cw_out),
    .count_load_o       (count_load),
    .count_load_value_o (count_load_value),
    .count_value0_i     (cv0),
    .count_value1_i     (cv1),
    .count_value2_i     (cv2),
    .status0_i          (st0),
    .status1_i          (st1),
    .status2_i          (st2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (|count_load) begin
      load_cnt  <= load_cnt + 1;
      last_mask <= count_load;
      last_val  <= count_load_value;
    end
    if (cw_write) cw_cnt <= cw_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add(input op_t op, input logic [1:0] a, input logic [7:0] d, input logic cs,
                     input logic [15:0] v, input logic [2:0] ld, input logic cw, input logic [7:0] rd);
    vec_t t;
    t.op = op; t.addr = a; t.data = d; t.cs_n = cs; t.val = v;
    t.exp_load = ld; t.exp_cw = cw; t.exp_rd = rd;
    vq.push_back(t);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input logic cs);
    bus_if.cs_n = cs; bus_if.addr = a; bus_if.data_in = d;
    cycles(2);
    bus_if.wr_n = 1'b0;
    cycles(6);
    bus_if.wr_n = 1'b1;
    cycles(6);
    bus_if.cs_n = 1'b1;
    cycles(2);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d, output logic v);
    bus_if.cs_n = 1'b0; bus_if.addr = a;
    cycles(2);
    bus_if.rd_n = 1'b0;
    cycles(6);
    d = bus_if.data_out;
    v = bus_if.data_out_valid;
    bus_if.rd_n = 1'b1;
    cycles(6);
    bus_if.cs_n = 1'b1;
    cycles(2);
  endtask

  initial begin
    int l0, c0;
    logic [7:0] rdat;
    logic rval;
    bus_if.cs_n = 1'b1; bus_if.rd_n = 1'b1; bus_if.wr_n = 1'b1;
    bus_if.addr = 2'd0; bus_if.data_in = 8'h00;
    cycles(3);
    rst_n = 1'b1;
    cycles(3);

    check("reset_data_out", {24'h0, bus_if.data_out}, 32'h0);
    check("reset_valid", {31'h0, bus_if.data_out_valid}, 32'h0);
    check("reset_cw", {23'h0, cw_write, cw_out}, 32'h0);
    check("reset_load", {13'h0, count_load, count_load_value}, 32'h0);

    // op, addr, data, cs_n, val, exp_load, exp_cw, exp_rd
    add(OP_WR, 3, 8'h30, 0, 16'h0000, 3'b000, 1, 8'h00);
    add(OP_WR, 0, 8'h34, 0, 16'h0000, 3'b000, 0, 8'h00);
    add(OP_WR, 0, 8'h12, 0, 16'h1234, 3'b001, 0, 8'h00);
    add(OP_WR, 3, 8'h50, 0, 16'h0000, 3'b000, 1, 8'h00);
    add(OP_WR, 1, 8'hAB, 0, 16'h00AB, 3'b010, 0, 8'h00);
    add(OP_WR, 1, 8'hCD, 0, 16'h00CD, 3'b010, 0, 8'h00);
    add(OP_WR, 1, 8'h77, 1, 16'h0000, 3'b000, 0, 8'h00);
    add(OP_WR, 3, 8'hB0, 0, 16'h0000, 3'b000, 1, 8'h00);
    add(OP_SET, 2, 8'h00, 0, 16'h5678, 3'b000, 0, 8'h00);
    add(OP_WR, 3, 8'h80, 0, 16'h0000, 3'b000, 0, 8'h00);
    add(OP_SET, 2, 8'h00, 0, 16'h0001, 3'b000, 0, 8'h00);
    add(OP_RD, 2, 8'h00, 0, 16'h0000, 3'b000, 0, 8'h78);
    add(OP_RD, 2, 8'h00, 0, 16'h0000, 3'b000, 0, 8'h56);
    add(OP_RD, 2, 8'h00, 0, 16'h0000, 3'b000, 0, 8'h01);
    add(OP_RD, 2, 8'h00, 0, 16'h0000, 3'b000, 0, 8'h00);
    add(OP_SET, 0, 8'h00, 0, 16'h4321, 3'b000, 0, 8'h00);
    add(OP_SET, 3, 8'h00, 0, 16'h00B6, 3'b000, 0, 8'h00);
    add(OP_WR, 3, 8'hE2, 0, 16'h0000, 3'b000, 0, 8'h00);
    add(OP_RD, 0, 8'h00, 0, 16'h0000, 3'b000, 0, 8'hB6);
    add(OP_RD, 0, 8'h00, 0, 16'h0000, 3'b000, 0, 8'h21);
    add(OP_RD, 0, 8'h00, 0, 16'h0000, 3'b000, 0, 8'h43);
    add(OP_SET, 1, 8'h00, 0, 16'h1111, 3'b000, 0, 8'h00);
    add(OP_WR, 3, 8'h40, 0, 16'h0000, 3'b000, 0, 8'h00);
    add(OP_SET, 1, 8'h00, 0, 16'h2222, 3'b000, 0, 8'h00);
    add(OP_WR, 3, 8'h40, 0, 16'h0000, 3'b000, 0, 8'h00);
    add(OP_RD, 1, 8'h00, 0, 16'h0000, 3'b000, 0, 8'h11);
    add(OP_RD, 1, 8'h00, 0, 16'h0000, 3'b000, 0, 8'h22);
    add(OP_RD, 3, 8'h00, 0, 16'h0000, 3'b000, 0, 8'h00);
    add(OP_WR, 3, 8'h60, 0, 16'h0000, 3'b000, 1, 8'h00);
    add(OP_WR, 1, 8'h9C, 0, 16'h9C00, 3'b010, 0, 8'h00);
    add(OP_WR, 0, 8'h11, 0, 16'h0000, 3'b000, 0, 8'h00);
    add(OP_WR, 3, 8'h30, 0, 16'h0000, 3'b000, 1, 8'h00);
    add(OP_WR, 0, 8'h22, 0, 16'h0000, 3'b000, 0, 8'h00);
    add(OP_WR, 0, 8'h33, 0, 16'h3322, 3'b001, 0, 8'h00);
    add(OP_WR, 0, 8'h55, 0, 16'h0000, 3'b000, 0, 8'h00);
    add(OP_RD, 0, 8'h00, 0, 16'h0000, 3'b000, 0, 8'h21);
    add(OP_WR, 0, 8'h66, 0, 16'h6655, 3'b001, 0, 8'h00);

    foreach (vq[i]) begin
      case (vq[i].op)
        OP_SET: begin
          case (vq[i].addr)
            2'd0: cv0 = vq[i].val;
            2'd1: cv1 = vq[i].val;
            2'd2: cv2 = vq[i].val;
            default: st0 = vq[i].val[7:0];
          endcase
          cycles(2);
        end
        OP_WR: begin
          l0 = load_cnt; c0 = cw_cnt;
          bus_write(vq[i].addr, vq[i].data, vq[i].cs_n);
          check($sformatf("v%0d_load_count", i), load_cnt - l0, (vq[i].exp_load != 3'b000) ? 1 : 0);
          if (vq[i].exp_load != 3'b000)
            check($sformatf("v%0d_load", i), {13'h0, last_mask, last_val},
                  {13'h0, vq[i].exp_load, vq[i].val});
          check($sformatf("v%0d_cw_count", i), cw_cnt - c0, {31'h0, vq[i].exp_cw});
          if (vq[i].exp_cw)
            check($sformatf("v%0d_cw_value", i), {24'h0, cw_out}, {24'h0, vq[i].data});
        end
        default: begin
          bus_read(vq[i].addr, rdat, rval);
          check($sformatf("v%0d_read", i), {23'h0, rval, rdat}, {23'h0, 1'b1, vq[i].exp_rd});
        end
      endcase
    end

    // Overlapping RD_n/WR_n: both ignored, no valid data, no load (ctr1 is RW=10).
    l0 = load_cnt;
    bus_if.cs_n = 1'b0; bus_if.addr = 2'd1; bus_if.data_in = 8'h01;
    cycles(2);
    bus_if.rd_n = 1'b0; bus_if.wr_n = 1'b0;
    cycles(6);
    check("overlap_valid", {31'h0, bus_if.data_out_valid}, 32'h0);
    bus_if.rd_n = 1'b1; bus_if.wr_n = 1'b1;
    cycles(6);
    bus_if.cs_n = 1'b1;
    cycles(2);
    check("overlap_load_count", load_cnt - l0, 0);

    // Reset while ctr0 sits in W_MSB: half-written count discarded, RW back to LSB-only.
    bus_write(2'd3, 8'h30, 1'b0);
    l0 = load_cnt;
    bus_write(2'd0, 8'h44, 1'b0);
    check("pre_reset_no_load", load_cnt - l0, 0);
    rst_n = 1'b0;
    cycles(2);
    check("in_reset_cw", {23'h0, cw_write, cw_out}, 32'h0);
    check("in_reset_load", {13'h0, count_load, count_load_value}, 32'h0);
    check("in_reset_data", {23'h0, bus_if.data_out_valid, bus_if.data_out}, 32'h0);
    rst_n = 1'b1;
    cycles(3);
    l0 = load_cnt;
    bus_write(2'd0, 8'h55, 1'b0);
    check("post_reset_load_count", load_cnt - l0, 1);
    check("post_reset_load", {13'h0, last_mask, last_val}, {13'h0, 3'b001, 16'h0055});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
